// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge, samples each bit at mid-period
// and presents the byte as a held register plus one-cycle valid / framing-error pulses.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 rx_s;
  logic                 rx_s_prev_q, rx_s_prev_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          bd_q, bd_d;
  logic [31:0]          bd_clamped_s, half_s;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 frame_err_q, frame_err_d;

  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign bd_clamped_s = (baud_div < 32'd2) ? 32'd2 : baud_div;
  assign half_s       = bd_q >> 1;

  // Next-state and datapath logic for the frame FSM and input synchronizer
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    rx_s_prev_d = rx_s;
    cnt_d       = cnt_q;
    bd_d        = bd_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Requiring rx_s_prev high means a line stuck low never retriggers
        if (rx_s_prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = 32'd0;
          bd_d    = bd_clamped_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == half_s - 32'd1) begin
          cnt_d = 32'd0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == bd_q - 32'd1) begin
          shift_d                = shift_q >> 1;
          shift_d[DATA_BITS-1]   = rx_s;
          cnt_d                  = 32'd0;
          idx_d                  = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == bd_q - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '1;
      rx_s_prev_q <= 1'b1;
      cnt_q       <= 32'd0;
      bd_q        <= 32'd0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_prev_q <= rx_s_prev_d;
      cnt_q       <= cnt_d;
      bd_q        <= bd_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serial driver plays the transmitter, and a queue of
// expected bytes / error counts built from what was sent is compared against observed pulses.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baud_div;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observations collected away from the active edge
  logic [7:0] got_q[$];
  int ferr_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural transmitter: start, 8 data bits LSB first, stop, then line high
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(per);
    end
    rx = stop_bit;
    tick(per);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; baud_div = 32'd4;
    tick(3);
    n_cmp += 4;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", rx_data); end
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [2];
    int f0;
    bytes[0] = 8'h55; bytes[1] = 8'hA3;
    baud_div = 32'd4;
    for (int k = 0; k < 2; k++) begin
      got_q.delete();
      f0 = ferr_cnt;
      send_frame(bytes[k], 1'b1, 4);
      tick(16);
      n_cmp += 3;
      if (got_q.size() != 1) begin
        n_bad++; $display("FAIL loop_count[%0d]: got %0d pulses expected 1", k, got_q.size());
      end else if (got_q[0] !== bytes[k]) begin
        n_bad++; $display("FAIL loop_data[%0d]: got %0h expected %0h", k, got_q[0], bytes[k]);
      end
      if (rx_data !== bytes[k]) begin n_bad++; $display("FAIL loop_hold[%0d]: got %0h expected %0h", k, rx_data, bytes[k]); end
      if (ferr_cnt != f0) begin n_bad++; $display("FAIL loop_ferr[%0d]: got %0d expected %0d", k, ferr_cnt, f0); end
    end
  endtask

  task automatic test_glitch();
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    baud_div = 32'd8;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(2);
    n_cmp += 4;
    if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy); end
    tick(8);
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b expected 0", rx_busy); end
    if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d pulses expected 0", got_q.size()); end
    if (ferr_cnt != f0) begin n_bad++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    logic [7:0] prev;
    got_q.delete();
    f0 = ferr_cnt;
    prev = 8'hA3;
    baud_div = 32'd4;
    send_frame(8'h3C, 1'b0, 4);
    tick(16);
    n_cmp += 5;
    if (ferr_cnt != f0 + 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    if (got_q.size() != 0) begin n_bad++; $display("FAIL ferr_valid: got %0d pulses expected 0", got_q.size()); end
    if (rx_data !== prev) begin n_bad++; $display("FAIL ferr_hold: got %0h expected %0h", rx_data, prev); end
    send_frame(8'h81, 1'b1, 4);
    tick(16);
    if (got_q.size() != 1) begin
      n_bad++; $display("FAIL ferr_next_count: got %0d expected 1", got_q.size());
    end else if (got_q[0] !== 8'h81) begin
      n_bad++; $display("FAIL ferr_next_data: got %0h expected 81", got_q[0]);
    end
    if (ferr_cnt != f0 + 1) begin n_bad++; $display("FAIL ferr_next_ferr: got %0d expected %0d", ferr_cnt, f0 + 1); end
  endtask

  task automatic test_reset_midframe();
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    baud_div = 32'd4;
    rx = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(4);
    end
    rx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    n_cmp += 7;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %0h expected 0", rx_data); end
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_ferr: got %b expected 0", frame_err); end
    rst = 1'b0;
    tick(30);
    if (got_q.size() != 0 || ferr_cnt != f0) begin
      n_bad++; $display("FAIL rstmid_nopulse: got %0d valid %0d ferr expected 0 0", got_q.size(), ferr_cnt - f0);
    end
    send_frame(8'h12, 1'b1, 4);
    tick(16);
    if (got_q.size() != 1) begin
      n_bad++; $display("FAIL rstmid_next_count: got %0d expected 1", got_q.size());
    end else if (got_q[0] !== 8'h12) begin
      n_bad++; $display("FAIL rstmid_next_data: got %0h expected 12", got_q[0]);
    end
    if (rx_data !== 8'h12) begin n_bad++; $display("FAIL rstmid_hold: got %0h expected 12", rx_data); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    baud_div = 32'd16;
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    tick(48);
    n_cmp += 1;
    if (got_q.size() != 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d expected 2", got_q.size());
    end else begin
      n_cmp += 2;
      if (got_q[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_first: got %0h expected 00", got_q[0]); end
      if (got_q[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got %0h expected ff", got_q[1]); end
    end
  endtask

  task automatic test_clamp();
    got_q.delete();
    baud_div = 32'd1;
    send_frame(8'hA5, 1'b1, 2);
    tick(12);
    n_cmp += 2;
    if (got_q.size() != 1) begin
      n_bad++; $display("FAIL clamp_count: got %0d expected 1", got_q.size());
    end else if (got_q[0] !== 8'hA5) begin
      n_bad++; $display("FAIL clamp_data: got %0h expected a5", got_q[0]);
    end
    if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL clamp_hold: got %0h expected a5", rx_data); end
  endtask

  // Random frames: reference is simply "good stop -> byte delivered, bad stop -> one error"
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    logic [7:0] b;
    logic       good;
    int         per, gap, f0, exp_ferr;
    got_q.delete();
    f0 = ferr_cnt;
    exp_ferr = 0;
    last_good = rx_data;
    for (int n = 0; n < 24; n++) begin
      per  = int'($urandom_range(2, 10));
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      baud_div = (per == 2 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1)) : 32'(per);
      send_frame(b, good, per);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_ferr++;
      end
      gap = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      tick(gap * per);
    end
    tick(40);
    n_cmp += 3;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
      end
    end
    if (ferr_cnt - f0 != exp_ferr) begin n_bad++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    if (rx_data !== last_good) begin n_bad++; $display("FAIL rand_hold: got %0h expected %0h", rx_data, last_good); end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("FAIL exclusive: got %0d overlap cycles expected 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    baud_div = 32'd4;
    test_reset();
    test_loopback();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    test_clamp();
    test_random();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the stage directly downstream of uart_tx, consuming the serial `tx` line.
- Frame format: 8N1, LSB first, line idles high.
- Receives one byte per frame and presents it as a one-cycle valid pulse plus a held data register.
- Uses the same runtime `baud_div` (clocks per bit) as uart_tx, so a tx/rx pair run with the same value loops back directly.

Parameters:
- DATA_BITS, 8: payload bits per frame; width of rx_data.
- SYNC_STAGES, 2: flip-flop stages in the rx input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- baud_div  input  32  clocks per bit period; values below 2 are treated as 2.
- rx  input  1  asynchronous serial input; idles high.
- rx_data  output  DATA_BITS  last correctly framed byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; rx_data is new in the same cycle.
- rx_busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset applies on any clock edge, including mid-frame: the partial frame is discarded and no pulse is emitted.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s and rx_s_prev.
- Divisor latch: `bd = max(baud_div, 2)` is captured at start detect. Changes to baud_div during a frame are ignored. `half = bd >> 1`.
- State machine (bit counter `cnt`, 32 bits; bit index `idx`):
  - IDLE:
    - rx_busy=0.
    - A falling edge (rx_s_prev=1, rx_s=0) moves to START, with cnt=0 and bd latched.
    - A line held low does not retrigger; a high level must be seen first.
  - START:
    - cnt increments each clock.
    - When cnt==half-1, sample rx_s.
    - If rx_s=0 → DATA, with cnt=0, idx=0.
    - If rx_s=1 → IDLE (glitch rejected). No pulse.
  - DATA:
    - When cnt==bd-1, sample rx_s into the shift register MSB and shift right (LSB-first assembly); set cnt=0 and idx++.
    - After the DATA_BITS-th sample → STOP.
  - STOP:
    - When cnt==bd-1, sample rx_s.
    - If 1: rx_data<=shift, rx_valid=1 for one cycle.
    - If 0: frame_err=1 for one cycle; rx_data unchanged.
    - Either case → IDLE on the next cycle.
- Sample points fall at mid-bit: the start bit is checked at half, and each later bit is sampled bd clocks after the previous sample.
- Latency: the rx_valid pulse occurs in the cycle after the stop-bit sample. That is about `half + (DATA_BITS+1)*bd + SYNC_STAGES + 1` clocks after the falling edge on rx.
- rx_valid and frame_err are never asserted together. Neither is asserted in IDLE except for the single cycle at the STOP→IDLE transition.
- Back-to-back frames:
  - A new start edge arriving at or after the stop sample is accepted once IDLE is reached.
  - The receiver returns to IDLE at mid-stop-bit, which leaves half a bit of margin.
- No FIFO and no overrun detection: a consumer that misses rx_valid loses only the pulse, not the data.
- Arithmetic: cnt compares are full 32-bit unsigned; wrap-around cannot occur because cnt is reset at each sample.

Test Plan:
1. Loopback: uart_tx → uart_rx, clk 100 MHz, baud_div=4.
   - Send 0x55 → exactly one rx_valid, rx_data=0x55, frame_err never set.
   - Then send 0xA3 → one rx_valid, rx_data=0xA3.
2. Glitch: baud_div=8; drive rx low for 2 clocks, then high → no rx_valid, no frame_err; rx_busy returns to 0 within 8 clocks.
3. Framing error: bit-bang 0x3C with stop bit = 0, baud_div=4.
   - frame_err pulses for one cycle; rx_valid=0; rx_data keeps its previous value.
   - A following good 0x81 frame (after the line returns high) → rx_valid with rx_data=0x81.
4. Reset mid-frame: assert rst during data bit 4 of a 0xFF frame → outputs return to reset values on the next edge, and no pulse occurs.
   - A following 0x12 frame is received correctly.
5. Back-to-back and clamping:
   - Two frames (0x00 then 0xFF) with zero idle bits between them at baud_div=16 → two rx_valid pulses with the correct values.
   - Repeat with baud_div=1 against a tx bit period of 2 clocks → 0xA5 is received correctly.
